// File: rtl/sense_trace_capture.sv
// Trigger-aligned trace capture: arm, wait for a trigger rising edge, skip DELAY valid samples,
// store LEN samples in RAM, then stream them out byte-by-byte over valid/ready.
module sense_trace_capture #(
    parameter int SW    = 7,
    parameter int AW    = 9,
    parameter int LEN   = 56,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic          trigger,
    input  logic [SW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          busy,
    output logic          armed,
    output logic          done,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last
);

    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SKIP,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t state, state_nxt;

    logic          trig_q;
    logic [15:0]   skip_cnt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [SW-1:0] mem [0:(2**AW)-1];

    logic trig_rise, skip_hit, cap_wr, cap_last, rd_fire, rd_fetch, rd_done;

    assign trig_rise = trigger && !trig_q;
    assign skip_hit  = (skip_cnt == 16'(DELAY - 1));
    assign cap_wr    = (state == S_CAPTURE) && sample_valid && !abort;
    assign cap_last  = (wptr == PW'(LEN - 1));
    assign rd_fire   = rd_valid && rd_ready;
    assign rd_done   = (state == S_READOUT) && rd_fire && rd_last;
    // Fetch when the output register is empty or being drained by a non-final handshake.
    assign rd_fetch  = (state == S_READOUT) && (rptr != PW'(LEN)) &&
                       (!rd_valid || (rd_fire && !rd_last));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm) state_nxt = S_ARMED;
                S_ARMED:   if (trig_rise) state_nxt = (DELAY > 0) ? S_SKIP : S_CAPTURE;
                S_SKIP:    if (sample_valid && skip_hit) state_nxt = S_CAPTURE;
                S_CAPTURE: if (cap_wr && cap_last) state_nxt = S_READOUT;
                S_READOUT: if (rd_done) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state != S_IDLE);
        armed = (state == S_ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst && cap_wr) begin
            mem[wptr[AW-1:0]] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_q   <= 1'b0;
            skip_cnt <= '0;
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            if (abort) begin
                skip_cnt <= '0;
                wptr     <= '0;
                rptr     <= '0;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                if (state == S_IDLE && arm) begin
                    wptr     <= '0;
                    skip_cnt <= '0;
                end
                if (state == S_SKIP && sample_valid) begin
                    skip_cnt <= skip_cnt + 16'd1;
                end
                if (cap_wr) begin
                    wptr <= wptr + PW'(1);
                end
                if (cap_wr && cap_last) begin
                    rptr <= '0;
                end
                if (rd_fetch) begin
                    rd_data  <= 8'(mem[rptr[AW-1:0]]);
                    rd_last  <= (rptr == PW'(LEN - 1));
                    rd_valid <= 1'b1;
                    rptr     <= rptr + PW'(1);
                end else if (rd_fire) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
                if (rd_done) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
